// File: rtl/timer_ctrl_fsm_if.sv
// Panel bundle for timer_ctrl_fsm: key pulses and ring level in, timer commands, presets and display status out.
// Latency: pure wiring, adds no cycles.
// Backpressure: none; keys are fire-and-forget pulses and commands are one-cycle strobes.
interface timer_ctrl_fsm_if;
  logic       key_mode;
  logic       key_inc;
  logic       key_start;
  logic       key_clear;
  logic       ring;
  logic       set_timer;
  logic       pause;
  logic       reset_timer;
  logic [7:0] hour_bcd_out;
  logic [7:0] minute_bcd_out;
  logic [7:0] second_bcd_out;
  logic [1:0] edit_sel;
  logic       blink;
  logic       buzzer;
  logic [2:0] state_out;

  // Key debouncers and the timer drive this side.
  modport master (
    output key_mode, key_inc, key_start, key_clear, ring,
    input  set_timer, pause, reset_timer,
    input  hour_bcd_out, minute_bcd_out, second_bcd_out,
    input  edit_sel, blink, buzzer, state_out
  );

  // The controller itself.
  modport slave (
    input  key_mode, key_inc, key_start, key_clear, ring,
    output set_timer, pause, reset_timer,
    output hour_bcd_out, minute_bcd_out, second_bcd_out,
    output edit_sel, blink, buzzer, state_out
  );
endinterface

// File: rtl/timer_ctrl_fsm.sv
// Front-panel FSM for count_down_timer: preset editing, start/pause/clear commands, buzzer on expiry.
// Latency: keys act one cycle after sampling; ring rise reaches buzzer two cycles later (edge register).
// Backpressure: none; optional macro TIMER_CTRL_AUTO_RESTART_EN makes an expired timer reload and restart.
module timer_ctrl_fsm #(
  parameter int RING_CYCLES  = 16,
  parameter int BLINK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  timer_ctrl_fsm_if.slave bus
);

  localparam int RCW = (RING_CYCLES  > 1) ? $clog2(RING_CYCLES)  : 1;
  localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [RCW-1:0] RING_LAST  = RCW'(RING_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_H  = 3'd1,
    EDIT_M  = 3'd2,
    EDIT_S  = 3'd3,
    LOAD    = 3'd4,
    RUN     = 3'd5,
    PAUSED  = 3'd6,
    RINGING = 3'd7
  } state_t;

  state_t         state;
  logic           ring_q1;
  logic           ring_q2;
  logic [7:0]     hour_bcd;
  logic [7:0]     minute_bcd;
  logic [7:0]     second_bcd;
  logic           set_timer_r;
  logic           pause_r;
  logic           reset_timer_r;
  logic [1:0]     edit_sel_r;
  logic           blink_r;
  logic           buzzer_r;
  logic [BCW-1:0] blink_cnt;
  logic [RCW-1:0] ring_cnt;

  logic ring_edge;
  logic preset_zero;
  logic any_key;

  // Edge taken between two registered copies so a ring already high on RUN entry never fires.
  assign ring_edge   = ring_q1 & ~ring_q2;
  assign preset_zero = (hour_bcd == 8'h00) && (minute_bcd == 8'h00) && (second_bcd == 8'h00);
  assign any_key     = bus.key_mode | bus.key_inc | bus.key_start | bus.key_clear;

  assign bus.set_timer      = set_timer_r;
  assign bus.pause          = pause_r;
  assign bus.reset_timer    = reset_timer_r;
  assign bus.hour_bcd_out   = hour_bcd;
  assign bus.minute_bcd_out = minute_bcd;
  assign bus.second_bcd_out = second_bcd;
  assign bus.edit_sel       = edit_sel_r;
  assign bus.blink          = blink_r;
  assign bus.buzzer         = buzzer_r;
  assign bus.state_out      = state;

  // BCD increment with wrap at 'top' (8'h23 for hours, 8'h59 for minutes/seconds).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Whole controller: state, presets, command pulses, display status and the blink/ring timers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ring_q1       <= 1'b0;
      ring_q2       <= 1'b0;
      hour_bcd      <= 8'h00;
      minute_bcd    <= 8'h00;
      second_bcd    <= 8'h00;
      set_timer_r   <= 1'b0;
      pause_r       <= 1'b0;
      reset_timer_r <= 1'b0;
      edit_sel_r    <= 2'd0;
      blink_r       <= 1'b0;
      buzzer_r      <= 1'b0;
      blink_cnt     <= '0;
      ring_cnt      <= '0;
    end else begin
      ring_q1       <= bus.ring;
      ring_q2       <= ring_q1;
      set_timer_r   <= 1'b0;
      pause_r       <= 1'b0;
      reset_timer_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_clear) begin
            hour_bcd      <= 8'h00;
            minute_bcd    <= 8'h00;
            second_bcd    <= 8'h00;
            reset_timer_r <= 1'b1;
          end else if (bus.key_start) begin
            if (!preset_zero) begin
              state       <= LOAD;
              set_timer_r <= 1'b1;
            end
          end else if (bus.key_mode) begin
            state      <= EDIT_H;
            edit_sel_r <= 2'd1;
            blink_r    <= 1'b1;
            blink_cnt  <= '0;
          end
        end
        EDIT_H, EDIT_M, EDIT_S: begin
          // Blink keeps running while the field stays selected; entries below restart it.
          if (blink_cnt == BLINK_LAST) begin
            blink_r   <= ~blink_r;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
          if (bus.key_clear) begin
            case (state)
              EDIT_H:  hour_bcd   <= 8'h00;
              EDIT_M:  minute_bcd <= 8'h00;
              default: second_bcd <= 8'h00;
            endcase
          end else if (bus.key_start) begin
            if (!preset_zero) begin
              state       <= LOAD;
              set_timer_r <= 1'b1;
              edit_sel_r  <= 2'd0;
              blink_r     <= 1'b0;
            end
          end else if (bus.key_mode) begin
            blink_r   <= 1'b1;
            blink_cnt <= '0;
            case (state)
              EDIT_H: begin
                state      <= EDIT_M;
                edit_sel_r <= 2'd2;
              end
              EDIT_M: begin
                state      <= EDIT_S;
                edit_sel_r <= 2'd3;
              end
              default: begin
                state       <= IDLE;
                edit_sel_r  <= 2'd0;
                blink_r     <= 1'b0;
                set_timer_r <= 1'b1;
              end
            endcase
          end else if (bus.key_inc) begin
            case (state)
              EDIT_H:  hour_bcd   <= bcd_inc(hour_bcd, 8'h23);
              EDIT_M:  minute_bcd <= bcd_inc(minute_bcd, 8'h59);
              default: second_bcd <= bcd_inc(second_bcd, 8'h59);
            endcase
          end
        end
        LOAD: begin
          state   <= RUN;
          pause_r <= 1'b1;
        end
        RUN: begin
          if (ring_edge) begin
            state    <= RINGING;
            buzzer_r <= 1'b1;
            ring_cnt <= '0;
          end else if (bus.key_clear) begin
            state         <= IDLE;
            reset_timer_r <= 1'b1;
          end else if (bus.key_start) begin
            state   <= PAUSED;
            pause_r <= 1'b1;
          end
        end
        PAUSED: begin
          if (bus.key_clear) begin
            state         <= IDLE;
            reset_timer_r <= 1'b1;
          end else if (bus.key_start) begin
            state   <= RUN;
            pause_r <= 1'b1;
          end
        end
        RINGING: begin
          if (any_key || (ring_cnt == RING_LAST)) begin
            buzzer_r <= 1'b0;
`ifdef TIMER_CTRL_AUTO_RESTART_EN
            if (bus.key_clear) begin
              state <= IDLE;
            end else begin
              state       <= LOAD;
              set_timer_r <= 1'b1;
            end
`else
            state       <= IDLE;
            set_timer_r <= 1'b1;
`endif
          end else begin
            ring_cnt <= ring_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Bench for timer_ctrl_fsm: random preset editing and run/ring scenarios against an integer preset model.
// Inputs change 1 time unit after the rising edge; outputs are read at that point and at the falling edge.
// A falling-edge monitor checks that command pulses are one cycle wide and mutually exclusive.
module tb_timer_ctrl_fsm;
  localparam int RC = 16;
  localparam int BC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  timer_ctrl_fsm_if bus ();

  timer_ctrl_fsm #(.RING_CYCLES(RC), .BLINK_CYCLES(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mh = 0, mm = 0, ms = 0;
  int n_set = 0, n_pause = 0, n_rst = 0;
  logic       mon_en = 1'b0;
  logic [2:0] prev_p = 3'b000;
  logic [2:0] cur_p;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  // Pulse shape monitor and pulse counters.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_p = {bus.set_timer, bus.pause, bus.reset_timer};
      chk("pulse_exclusive", int'($countones(cur_p) <= 1), 1);
      chk("pulse_width", int'((cur_p & prev_p) == 3'b000), 1);
      prev_p  <= cur_p;
      n_set   <= n_set + int'(cur_p[2]);
      n_pause <= n_pause + int'(cur_p[1]);
      n_rst   <= n_rst + int'(cur_p[0]);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // k: 0 mode, 1 inc, 2 start, 3 clear.  Key is high for exactly one sampled edge.
  task automatic press(input int k);
    case (k)
      0:       bus.key_mode  = 1'b1;
      1:       bus.key_inc   = 1'b1;
      2:       bus.key_start = 1'b1;
      default: bus.key_clear = 1'b1;
    endcase
    tick();
    bus.key_mode  = 1'b0;
    bus.key_inc   = 1'b0;
    bus.key_start = 1'b0;
    bus.key_clear = 1'b0;
  endtask

  task automatic chk_preset(input string tag);
    chk({tag, "_hour"}, int'(bus.hour_bcd_out), bcd(mh));
    chk({tag, "_min"},  int'(bus.minute_bcd_out), bcd(mm));
    chk({tag, "_sec"},  int'(bus.second_bcd_out), bcd(ms));
  endtask

  // From IDLE: clear each field, increment it n times, return to IDLE.
  task automatic set_preset(input int h, input int m, input int s);
    int w;
    press(0);
    chk("edit_h_state", int'(bus.state_out), 1);
    chk("edit_h_sel", int'(bus.edit_sel), 1);
    chk("edit_h_blink_entry", int'(bus.blink), 1);
    w = $urandom_range(0, 3 * BC);
    repeat (w) tick();
    chk("edit_blink_phase", int'(bus.blink), int'(((w / BC) % 2) == 0));
    press(3); mh = 0;
    repeat (h) begin press(1); mh = (mh + 1) % 24; end
    press(0);
    chk("edit_m_sel", int'(bus.edit_sel), 2);
    chk("edit_m_blink_entry", int'(bus.blink), 1);
    press(3); mm = 0;
    repeat (m) begin press(1); mm = (mm + 1) % 60; end
    press(0);
    chk("edit_s_sel", int'(bus.edit_sel), 3);
    press(3); ms = 0;
    repeat (s) begin press(1); ms = (ms + 1) % 60; end
    chk_preset("edit");
    press(0);
    chk("edit_exit_set", int'(bus.set_timer), 1);
    chk("edit_exit_state", int'(bus.state_out), 0);
    chk("edit_exit_sel", int'(bus.edit_sel), 0);
    chk("edit_exit_blink", int'(bus.blink), 0);
    tick();
  endtask

  task automatic start_run();
    press(2);
    chk("start_set", int'(bus.set_timer), 1);
    chk("start_load_state", int'(bus.state_out), 4);
    tick();
    chk("start_pause", int'(bus.pause), 1);
    chk("start_run_state", int'(bus.state_out), 5);
    tick();
    chk("start_pause_end", int'(bus.pause), 0);
  endtask

  // From RUN: raise ring and land in RINGING two cycles later.
  task automatic ring_to_ringing();
    bus.ring = 1'b1;
    tick();
    chk("ring_lat1_buzzer", int'(bus.buzzer), 0);
    tick();
    chk("ring_lat2_buzzer", int'(bus.buzzer), 1);
    chk("ring_state", int'(bus.state_out), 7);
  endtask

  // Called on the cycle the buzzer dropped; brings the design back to IDLE.
  task automatic ring_exit(input bit by_clear);
`ifdef TIMER_CTRL_AUTO_RESTART_EN
    if (by_clear) begin
      chk("ring_exit_idle", int'(bus.state_out), 0);
      chk("ring_exit_noset", int'(bus.set_timer), 0);
    end else begin
      chk("ring_exit_load", int'(bus.state_out), 4);
      chk("ring_exit_set", int'(bus.set_timer), 1);
      tick();
      chk("ring_restart_run", int'(bus.state_out), 5);
      chk("ring_restart_pause", int'(bus.pause), 1);
      tick();
      press(3);
      chk("ring_restart_clear", int'(bus.state_out), 0);
    end
`else
    chk("ring_exit_idle", int'(bus.state_out), 0);
    chk("ring_exit_set", int'(bus.set_timer), int'(!by_clear || 1'b1));
`endif
    tick();
  endtask

  initial begin
    int cnt, guard, k, w, p0;
    bus.key_mode = 1'b0; bus.key_inc = 1'b0; bus.key_start = 1'b0;
    bus.key_clear = 1'b0; bus.ring = 1'b0;

    // Reset state
    repeat (3) tick();
    mon_en = 1'b1;
    chk("rst_state", int'(bus.state_out), 0);
    chk_preset("rst");
    chk("rst_sel", int'(bus.edit_sel), 0);
    chk("rst_blink", int'(bus.blink), 0);
    chk("rst_buzzer", int'(bus.buzzer), 0);
    rst_n = 1'b1;
    tick();

    // Start with the model preset (zero after reset) is ignored
    p0 = n_set + n_pause + n_rst;
    press(2);
    tick();
    chk("zero_start_state", int'(bus.state_out), (mh + mm + ms == 0) ? 0 : 5);
    chk("zero_start_pulses", n_set + n_pause + n_rst - p0, (mh + mm + ms == 0) ? 0 : 2);

    // Editing to 02:30:15
    set_preset(2, 30, 15);
    chk("edit_const_h", int'(bus.hour_bcd_out), 'h02);
    chk("edit_const_m", int'(bus.minute_bcd_out), 'h30);
    chk("edit_const_s", int'(bus.second_bcd_out), 'h15);

    // Wrap cases
    press(0); press(3);
    repeat (24) press(1);
    chk("wrap_hour", int'(bus.hour_bcd_out), 'h00);
    press(0); press(3);
    repeat (59) press(1);
    chk("wrap_min59", int'(bus.minute_bcd_out), 'h59);
    press(1);
    chk("wrap_min00", int'(bus.minute_bcd_out), 'h00);
    press(0); press(3);
    repeat (9) press(1);
    chk("wrap_sec09", int'(bus.second_bcd_out), 'h09);
    press(1);
    chk("wrap_sec10", int'(bus.second_bcd_out), 'h10);
    press(0);
    chk("wrap_exit_set", int'(bus.set_timer), 1);
    mh = 0; mm = 0; ms = 10;
    tick();

    // Random presets with start / pause / resume / clear
    for (int it = 0; it < 3; it++) begin
      set_preset($urandom_range(0, 30), $urandom_range(0, 70), $urandom_range(1, 70));
      start_run();
      repeat ($urandom_range(0, 5)) tick();
      press(2);
      chk("pause_pulse", int'(bus.pause), 1);
      chk("paused_state", int'(bus.state_out), 6);
      tick();
      press(2);
      chk("resume_pulse", int'(bus.pause), 1);
      chk("resume_state", int'(bus.state_out), 5);
      tick();
      press(3);
      chk("run_clear_rst", int'(bus.reset_timer), 1);
      chk("run_clear_state", int'(bus.state_out), 0);
      chk_preset("retain");
      tick();
    end

    // Start directly from an edit field
    press(0);
    press(2);
    chk("edit_start_state", int'(bus.state_out), 4);
    chk("edit_start_sel", int'(bus.edit_sel), 0);
    tick();
    chk("edit_start_run", int'(bus.state_out), 5);
    tick();
    press(3);
    tick();

    // IDLE clear zeroes the preset
    press(3);
    chk("idle_clear_rst", int'(bus.reset_timer), 1);
    mh = 0; mm = 0; ms = 0;
    chk_preset("idle_clear");
    tick();

    // Expiry with timeout at 00:00:05
    set_preset(0, 0, 5);
    start_run();
    ring_to_ringing();
    cnt = 1; guard = 0;
    while (bus.buzzer && guard < 4 * RC) begin
      tick();
      guard++;
      if (bus.buzzer) cnt++;
    end
    chk("ring_length", cnt, RC);
    bus.ring = 1'b0;
    ring_exit(1'b0);

    // Key during RINGING exits the next cycle
    for (int it = 0; it < 4; it++) begin
      k = (it == 0) ? 3 : int'($urandom_range(0, 3));
      w = $urandom_range(0, RC - 4);
      start_run();
      ring_to_ringing();
      repeat (w) tick();
      chk("ringkey_before", int'(bus.buzzer), 1);
      press(k);
      bus.ring = 1'b0;
      chk("ringkey_buzzer", int'(bus.buzzer), 0);
      ring_exit(k == 3);
    end

    // Start and clear together in RUN: only reset_timer
    start_run();
    p0 = n_pause;
    bus.key_start = 1'b1; bus.key_clear = 1'b1;
    tick();
    bus.key_start = 1'b0; bus.key_clear = 1'b0;
    chk("coll_sc_rst", int'(bus.reset_timer), 1);
    chk("coll_sc_pause", int'(bus.pause), 0);
    chk("coll_sc_state", int'(bus.state_out), 0);
    tick();
    chk("coll_sc_npause", n_pause - p0, 0);

    // Ring edge and start in the same cycle: RINGING, no pause
    start_run();
    p0 = n_pause;
    bus.ring = 1'b1;
    tick();
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
    chk("coll_rs_state", int'(bus.state_out), 7);
    chk("coll_rs_pause", int'(bus.pause), 0);
    tick();
    chk("coll_rs_npause", n_pause - p0, 0);
    press(3);
    bus.ring = 1'b0;
    ring_exit(1'b1);

    // PAUSED ignores ring edges
    start_run();
    press(2);
    tick();
    bus.ring = 1'b1;
    repeat (4) tick();
    chk("paused_ring_state", int'(bus.state_out), 6);
    chk("paused_ring_buzzer", int'(bus.buzzer), 0);
    bus.ring = 1'b0;
    tick();
    press(3);
    chk("paused_clear_state", int'(bus.state_out), 0);
    tick();

    // Reset for 3 cycles mid-RUN
    start_run();
    rst_n = 1'b0;
    tick();
    chk("midrst_state", int'(bus.state_out), 0);
    tick(); tick();
    rst_n = 1'b1;
    mh = 0; mm = 0; ms = 0;
    chk("midrst_state2", int'(bus.state_out), 0);
    chk_preset("midrst");
    chk("midrst_buzzer", int'(bus.buzzer), 0);
    chk("midrst_pulses", int'({bus.set_timer, bus.pause, bus.reset_timer}), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
